// File: rtl/branch_resolve_ctrl_if.sv
// Bundle between the microcode sequencer, the ALU and branch_resolve_ctrl.
// master: sequencer/ALU side; slave: the controller.
interface branch_resolve_ctrl_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic            is_jal;
    logic            is_jalr;
    logic            is_branch;
    logic [2:0]      funct3;
    logic            busy;
    logic            alu_req;
    logic [1:0]      alu_op;
    logic            alu_ack;
    logic            alu_zero;
    logic            alu_lsb;
    logic            branch_signal;
    logic [1:0]      branch_type;
    logic            taken;
    logic [1:0]      pc_sel;
    logic            done;
    logic            error;
    logic [XLEN-1:0] br_count;
    logic [XLEN-1:0] br_taken_count;

    modport master (
        output start, is_jal, is_jalr, is_branch, funct3, alu_ack, alu_zero, alu_lsb,
        input  busy, alu_req, alu_op, branch_signal, branch_type, taken, pc_sel,
               done, error, br_count, br_taken_count
    );

    modport slave (
        input  start, is_jal, is_jalr, is_branch, funct3, alu_ack, alu_zero, alu_lsb,
        output busy, alu_req, alu_op, branch_signal, branch_type, taken, pc_sel,
               done, error, br_count, br_taken_count
    );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// Branch/jump resolution sequencer; BRANCH_PERF_EN adds saturating branch counters.
// Latency: JAL 3, non-branch/illegal 2, ALU ops 4 + ALU wait cycles (start to done).
// Backpressure: start ignored while busy; alu_req held until alu_ack or timeout.
module branch_resolve_ctrl #(
    parameter int XLEN        = 32,
    parameter int ALU_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    branch_resolve_ctrl_if.slave bus
);
    localparam int TW = $clog2(ALU_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, DECODE, CMP, RESOLVE, DONE} state_t;
    state_t state, stateNext;

    logic          isJalQ, isJalrQ, isBranchQ;
    logic [2:0]    funct3Q;
    logic          zeroQ, lsbQ;
    logic [TW-1:0] waitCnt;
    logic          takenQ, errorQ;
    logic [1:0]    pcSelQ;

    logic          condBranch, f3Legal, timeoutHit, condMet;
    logic [1:0]    brType, cmpOp;

    // jal/jalr take priority, so a conditional branch is only is_branch alone
    assign condBranch = !isJalQ && !isJalrQ && isBranchQ;
    assign f3Legal    = (funct3Q[2:1] != 2'b01);
    assign timeoutHit = (waitCnt == TW'(ALU_TIMEOUT));

    always_comb begin
        brType = 2'b00;
        cmpOp  = 2'b00;
        case (funct3Q)
            3'b000:  begin brType = 2'b00; cmpOp = 2'b00; end
            3'b001:  begin brType = 2'b01; cmpOp = 2'b00; end
            3'b100:  begin brType = 2'b10; cmpOp = 2'b01; end
            3'b101:  begin brType = 2'b11; cmpOp = 2'b01; end
            3'b110:  begin brType = 2'b10; cmpOp = 2'b10; end
            3'b111:  begin brType = 2'b11; cmpOp = 2'b10; end
            default: begin brType = 2'b00; cmpOp = 2'b00; end
        endcase
    end

    always_comb begin
        case (brType)
            2'b00:   condMet = zeroQ;
            2'b01:   condMet = !zeroQ;
            2'b10:   condMet = lsbQ;
            default: condMet = !lsbQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (bus.start) stateNext = DECODE;
            DECODE: begin
                if (isJalQ)                     stateNext = RESOLVE;
                else if (isJalrQ)               stateNext = CMP;
                else if (isBranchQ && f3Legal)  stateNext = CMP;
                else                            stateNext = DONE;
            end
            CMP: begin
                if (bus.alu_ack)     stateNext = RESOLVE;
                else if (timeoutHit) stateNext = DONE;
            end
            RESOLVE: stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        bus.busy          = (state != IDLE);
        bus.alu_req       = (state == CMP);
        bus.alu_op        = (state == CMP) ? (isJalrQ ? 2'b11 : cmpOp) : 2'b00;
        bus.branch_signal = condBranch && f3Legal &&
                            (state == CMP || state == RESOLVE || state == DONE);
        bus.branch_type   = bus.branch_signal ? brType : 2'b00;
        bus.done          = (state == DONE);
    end

    assign bus.taken  = takenQ;
    assign bus.pc_sel = pcSelQ;
    assign bus.error  = errorQ;

    always_ff @(posedge clk) begin
        if (reset) begin
            isJalQ    <= 1'b0;
            isJalrQ   <= 1'b0;
            isBranchQ <= 1'b0;
            funct3Q   <= 3'b000;
            zeroQ     <= 1'b0;
            lsbQ      <= 1'b0;
            waitCnt   <= '0;
            takenQ    <= 1'b0;
            pcSelQ    <= 2'b00;
            errorQ    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    isJalQ    <= bus.is_jal;
                    isJalrQ   <= bus.is_jalr;
                    isBranchQ <= bus.is_branch;
                    funct3Q   <= bus.funct3;
                    errorQ    <= 1'b0;
                end
                DECODE: if (!isJalQ && !isJalrQ && !(isBranchQ && f3Legal)) begin
                    takenQ <= 1'b0;
                    pcSelQ <= 2'b00;
                    errorQ <= isBranchQ;
                end
                CMP: begin
                    if (bus.alu_ack) begin
                        zeroQ   <= bus.alu_zero;
                        lsbQ    <= bus.alu_lsb;
                        waitCnt <= '0;
                    end else if (timeoutHit) begin
                        takenQ  <= 1'b0;
                        pcSelQ  <= 2'b00;
                        errorQ  <= 1'b1;
                        waitCnt <= '0;
                    end else begin
                        waitCnt <= waitCnt + TW'(1);
                    end
                end
                RESOLVE: begin
                    if (isJalQ) begin
                        takenQ <= 1'b1;
                        pcSelQ <= 2'b01;
                    end else if (isJalrQ) begin
                        takenQ <= 1'b1;
                        pcSelQ <= 2'b10;
                    end else begin
                        takenQ <= condMet;
                        pcSelQ <= condMet ? 2'b01 : 2'b00;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef BRANCH_PERF_EN
    logic [XLEN-1:0] brCnt, brTakenCnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            brCnt      <= '0;
            brTakenCnt <= '0;
        end else if (state == RESOLVE && condBranch) begin
            if (brCnt != '1) brCnt <= brCnt + XLEN'(1);
            if (condMet && brTakenCnt != '1) brTakenCnt <= brTakenCnt + XLEN'(1);
        end
    end

    assign bus.br_count       = brCnt;
    assign bus.br_taken_count = brTakenCnt;
`else
    assign bus.br_count       = {XLEN{1'b0}};
    assign bus.br_taken_count = {XLEN{1'b0}};
`endif
endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl; counter expectations follow BRANCH_PERF_EN.
module tb_branch_resolve_ctrl;
    localparam int XLEN = 32;
`ifdef BRANCH_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk;
    logic reset;
    int   total;
    int   bad;

    branch_resolve_ctrl_if #(.XLEN(XLEN)) bus ();

    branch_resolve_ctrl #(.XLEN(XLEN), .ALU_TIMEOUT(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raises start for one cycle; returns observing cycle N+1.
    task automatic start_op(input logic jal, input logic jalr, input logic br, input logic [2:0] f3);
        bus.is_jal    = jal;
        bus.is_jalr   = jalr;
        bus.is_branch = br;
        bus.funct3    = f3;
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", bus.busy); end total++;
        if (bus.done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", bus.done); end total++;
        if (bus.alu_req !== 1'b0) begin bad++; $display("FAIL rst_alu_req: got %b want 0", bus.alu_req); end total++;
        if (bus.taken !== 1'b0 || bus.pc_sel !== 2'b00 || bus.error !== 1'b0) begin bad++; $display("FAIL rst_result: got taken=%b pc_sel=%b error=%b want 0 00 0", bus.taken, bus.pc_sel, bus.error); end total++;
        if (bus.br_count !== '0 || bus.br_taken_count !== '0) begin bad++; $display("FAIL rst_counters: got %0d %0d want 0 0", bus.br_count, bus.br_taken_count); end total++;
        reset = 1'b0;
        tick();
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_idle: got busy=%b want 0", bus.busy); end total++;
    endtask

    task automatic test_bgeu_wait();
        start_op(1'b0, 1'b0, 1'b1, 3'b111);
        if (bus.busy !== 1'b1 || bus.alu_req !== 1'b0) begin bad++; $display("FAIL bgeu_decode: got busy=%b alu_req=%b want 1 0", bus.busy, bus.alu_req); end total++;
        tick();
        if (bus.alu_req !== 1'b1 || bus.alu_op !== 2'b10) begin bad++; $display("FAIL bgeu_op: got req=%b op=%b want 1 10", bus.alu_req, bus.alu_op); end total++;
        if (bus.branch_signal !== 1'b1 || bus.branch_type !== 2'b11) begin bad++; $display("FAIL bgeu_mux: got sig=%b type=%b want 1 11", bus.branch_signal, bus.branch_type); end total++;
        tick(); tick(); tick();
        if (bus.alu_req !== 1'b1 || bus.alu_op !== 2'b10 || bus.done !== 1'b0) begin bad++; $display("FAIL bgeu_hold: got req=%b op=%b done=%b want 1 10 0", bus.alu_req, bus.alu_op, bus.done); end total++;
        bus.alu_ack = 1'b1; bus.alu_lsb = 1'b1; bus.alu_zero = 1'b0;
        tick();
        bus.alu_ack = 1'b0;
        if (bus.done !== 1'b0 || bus.alu_req !== 1'b0) begin bad++; $display("FAIL bgeu_resolve: got done=%b req=%b want 0 0", bus.done, bus.alu_req); end total++;
        tick();
        if (bus.done !== 1'b1 || bus.taken !== 1'b0 || bus.pc_sel !== 2'b00 || bus.error !== 1'b0) begin bad++; $display("FAIL bgeu_done: got done=%b taken=%b pc_sel=%b err=%b want 1 0 00 0", bus.done, bus.taken, bus.pc_sel, bus.error); end total++;
        if (bus.br_count !== (PERF ? 32'd1 : 32'd0) || bus.br_taken_count !== 32'd0) begin bad++; $display("FAIL bgeu_counters: got %0d %0d want %0d 0", bus.br_count, bus.br_taken_count, PERF ? 1 : 0); end total++;
        tick();
    endtask

    task automatic test_beq();
        start_op(1'b0, 1'b0, 1'b1, 3'b000);
        tick();
        if (bus.alu_op !== 2'b00 || bus.branch_type !== 2'b00 || bus.branch_signal !== 1'b1) begin bad++; $display("FAIL beq_cmp: got op=%b type=%b sig=%b want 00 00 1", bus.alu_op, bus.branch_type, bus.branch_signal); end total++;
        bus.alu_ack = 1'b1; bus.alu_zero = 1'b1; bus.alu_lsb = 1'b0;
        tick();
        bus.alu_ack = 1'b0;
        tick();
        if (bus.done !== 1'b1 || bus.taken !== 1'b1 || bus.pc_sel !== 2'b01) begin bad++; $display("FAIL beq_done: got done=%b taken=%b pc_sel=%b want 1 1 01", bus.done, bus.taken, bus.pc_sel); end total++;
        if (bus.br_count !== (PERF ? 32'd2 : 32'd0) || bus.br_taken_count !== (PERF ? 32'd1 : 32'd0)) begin bad++; $display("FAIL beq_counters: got %0d %0d", bus.br_count, bus.br_taken_count); end total++;
        tick();
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.taken !== 1'b1 || bus.pc_sel !== 2'b01) begin bad++; $display("FAIL beq_idle_hold: got done=%b busy=%b taken=%b pc_sel=%b want 0 0 1 01", bus.done, bus.busy, bus.taken, bus.pc_sel); end total++;
    endtask

    task automatic test_illegal();
        start_op(1'b0, 1'b0, 1'b1, 3'b010);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        if (bus.done !== 1'b1 || bus.error !== 1'b1 || bus.taken !== 1'b0 || bus.pc_sel !== 2'b00) begin bad++; $display("FAIL illegal_done: got done=%b err=%b taken=%b pc_sel=%b want 1 1 0 00", bus.done, bus.error, bus.taken, bus.pc_sel); end total++;
        tick();
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.error !== 1'b1) begin bad++; $display("FAIL illegal_ignore_start: got busy=%b done=%b err=%b want 0 0 1", bus.busy, bus.done, bus.error); end total++;
    endtask

    task automatic test_back_to_back();
        start_op(1'b1, 1'b0, 1'b0, 3'b000);
        if (bus.alu_req !== 1'b0 || bus.error !== 1'b0) begin bad++; $display("FAIL jal_decode: got req=%b err=%b want 0 0", bus.alu_req, bus.error); end total++;
        tick();
        if (bus.alu_req !== 1'b0 || bus.done !== 1'b0) begin bad++; $display("FAIL jal_resolve: got req=%b done=%b want 0 0", bus.alu_req, bus.done); end total++;
        tick();
        if (bus.done !== 1'b1 || bus.taken !== 1'b1 || bus.pc_sel !== 2'b01 || bus.alu_req !== 1'b0) begin bad++; $display("FAIL jal_done: got done=%b taken=%b pc_sel=%b req=%b want 1 1 01 0", bus.done, bus.taken, bus.pc_sel, bus.alu_req); end total++;
        tick();
        start_op(1'b0, 1'b1, 1'b0, 3'b000);
        tick();
        if (bus.alu_req !== 1'b1 || bus.alu_op !== 2'b11 || bus.branch_signal !== 1'b0) begin bad++; $display("FAIL jalr_cmp: got req=%b op=%b sig=%b want 1 11 0", bus.alu_req, bus.alu_op, bus.branch_signal); end total++;
        bus.alu_ack = 1'b1; bus.alu_zero = 1'b0; bus.alu_lsb = 1'b0;
        tick();
        bus.alu_ack = 1'b0;
        tick();
        if (bus.done !== 1'b1 || bus.taken !== 1'b1 || bus.pc_sel !== 2'b10) begin bad++; $display("FAIL jalr_done: got done=%b taken=%b pc_sel=%b want 1 1 10", bus.done, bus.taken, bus.pc_sel); end total++;
        tick();
    endtask

    task automatic test_timeout();
        start_op(1'b0, 1'b1, 1'b0, 3'b000);
        tick();
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (bus.alu_req !== 1'b1 || bus.done !== 1'b0) begin bad++; $display("FAIL timeout_wait%0d: got req=%b done=%b want 1 0", i, bus.alu_req, bus.done); end total++;
        end
        tick();
        if (bus.done !== 1'b1 || bus.error !== 1'b1 || bus.taken !== 1'b0 || bus.pc_sel !== 2'b00) begin bad++; $display("FAIL timeout_done: got done=%b err=%b taken=%b pc_sel=%b want 1 1 0 00", bus.done, bus.error, bus.taken, bus.pc_sel); end total++;
        tick();
    endtask

    task automatic test_non_branch();
        start_op(1'b0, 1'b0, 1'b0, 3'b101);
        if (bus.error !== 1'b0 || bus.done !== 1'b0) begin bad++; $display("FAIL nonbr_decode: got err=%b done=%b want 0 0", bus.error, bus.done); end total++;
        tick();
        if (bus.done !== 1'b1 || bus.taken !== 1'b0 || bus.pc_sel !== 2'b00 || bus.error !== 1'b0) begin bad++; $display("FAIL nonbr_done: got done=%b taken=%b pc_sel=%b err=%b want 1 0 00 0", bus.done, bus.taken, bus.pc_sel, bus.error); end total++;
        tick();
    endtask

    task automatic test_ack_at_expiry();
        start_op(1'b0, 1'b0, 1'b1, 3'b001);
        tick();
        for (int i = 1; i <= 16; i++) tick();
        if (bus.alu_req !== 1'b1) begin bad++; $display("FAIL expiry_req: got %b want 1", bus.alu_req); end total++;
        bus.alu_ack = 1'b1; bus.alu_zero = 1'b0; bus.alu_lsb = 1'b0;
        tick();
        bus.alu_ack = 1'b0;
        if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin bad++; $display("FAIL expiry_resolve: got done=%b busy=%b want 0 1", bus.done, bus.busy); end total++;
        tick();
        if (bus.done !== 1'b1 || bus.error !== 1'b0 || bus.taken !== 1'b1 || bus.pc_sel !== 2'b01) begin bad++; $display("FAIL expiry_done: got done=%b err=%b taken=%b pc_sel=%b want 1 0 1 01", bus.done, bus.error, bus.taken, bus.pc_sel); end total++;
        if (bus.br_count !== (PERF ? 32'd3 : 32'd0) || bus.br_taken_count !== (PERF ? 32'd2 : 32'd0)) begin bad++; $display("FAIL expiry_counters: got %0d %0d", bus.br_count, bus.br_taken_count); end total++;
        tick();
    endtask

    task automatic test_reset_mid();
        start_op(1'b0, 1'b0, 1'b1, 3'b100);
        tick();
        if (bus.alu_req !== 1'b1 || bus.alu_op !== 2'b01 || bus.branch_type !== 2'b10) begin bad++; $display("FAIL rmid_cmp: got req=%b op=%b type=%b want 1 01 10", bus.alu_req, bus.alu_op, bus.branch_type); end total++;
        reset = 1'b1;
        tick();
        if (bus.busy !== 1'b0 || bus.alu_req !== 1'b0 || bus.done !== 1'b0 || bus.branch_signal !== 1'b0) begin bad++; $display("FAIL rmid_ctrl: got busy=%b req=%b done=%b sig=%b want 0 0 0 0", bus.busy, bus.alu_req, bus.done, bus.branch_signal); end total++;
        if (bus.taken !== 1'b0 || bus.pc_sel !== 2'b00 || bus.error !== 1'b0) begin bad++; $display("FAIL rmid_result: got taken=%b pc_sel=%b err=%b want 0 00 0", bus.taken, bus.pc_sel, bus.error); end total++;
        if (bus.br_count !== '0 || bus.br_taken_count !== '0) begin bad++; $display("FAIL rmid_counters: got %0d %0d want 0 0", bus.br_count, bus.br_taken_count); end total++;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL rmid_quiet%0d: got done=%b busy=%b want 0 0", i, bus.done, bus.busy); end total++;
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.start = 1'b0; bus.is_jal = 1'b0; bus.is_jalr = 1'b0; bus.is_branch = 1'b0;
        bus.funct3 = 3'b000; bus.alu_ack = 1'b0; bus.alu_zero = 1'b0; bus.alu_lsb = 1'b0;
        test_reset();
        test_bgeu_wait();
        test_beq();
        test_illegal();
        test_back_to_back();
        test_timeout();
        test_non_branch();
        test_ack_at_expiry();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/branch_resolve_ctrl.md
# branch_resolve_ctrl

Multi-cycle controller that sequences branch and jump resolution for the non-pipelined, microprogrammed RV32I core. It is started by the microcode sequencer and decodes the instruction class and funct3. For conditional branches and JALR it requests one ALU operation, then drives the branch-decision mux inputs (branch_signal, branch_type). It returns a registered taken/pc_sel result to the PC update logic with a done pulse.

## Interface
Parameters:
- XLEN, 32, datapath width; sets the width of the performance counters.
- ALU_TIMEOUT, 16, maximum number of CMP cycles to wait for alu_ack; must be at least 2.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle request from the microcode sequencer; accepted only in IDLE.
- is_jal, is_jalr, is_branch  in  1 each  instruction class; sampled with start.
- funct3  in  3  branch condition field; sampled with start.
- busy  out  1  high in every state except IDLE.
- alu_req  out  1  ALU operation request; held high until alu_ack.
- alu_op  out  2  00 SUB, 01 SLT, 10 SLTU, 11 ADD.
- alu_ack  in  1  ALU result valid.
- alu_zero, alu_lsb  in  1 each  ALU zero flag and result bit 0; captured on alu_ack.
- branch_signal  out  1  to the branch-decision mux.
- branch_type  out  2  to the branch-decision mux.
- taken  out  1  registered resolution.
- pc_sel  out  2  00 PC+4, 01 PC+imm, 10 ALU (rs1+imm).
- done  out  1  one-cycle completion pulse.
- error  out  1  pulses with done on illegal funct3 or ALU timeout.
- br_count, br_taken_count  out  XLEN each  performance counters.

## Operation
- Priority of class inputs: is_jal > is_jalr > is_branch. If none is set, the instruction is a non-branch: taken=0, pc_sel=00.
- funct3 decode (branch_type, alu_op):
  - 000 BEQ: 00, SUB.
  - 001 BNE: 01, SUB.
  - 100 BLT: 10, SLT.
  - 101 BGE: 11, SLT.
  - 110 BLTU: 10, SLTU.
  - 111 BGEU: 11, SLTU.
  - 010 and 011 are illegal.
- Resolution: taken = branch_signal & (type 00: zero; 01: !zero; 10: lsb; 11: !lsb), using the flags captured on alu_ack.
- FSM states and transitions:
  - IDLE: on start, latch the inputs and go to DECODE.
  - DECODE: JAL goes to RESOLVE. Non-branch goes to DONE. Illegal funct3 goes to DONE with error. JALR (alu_op=ADD) and legal branches go to CMP.
  - CMP: alu_req=1. On alu_ack, capture the flags and go to RESOLVE. After ALU_TIMEOUT cycles without alu_ack, go to DONE with error, taken=0, pc_sel=00.
  - RESOLVE: register the outcome, then go to DONE.
    - JAL: taken=1, pc_sel=01.
    - JALR: taken=1, pc_sel=10.
    - Branch: pc_sel=01 if taken, else 00.
  - DONE: done=1, then go to IDLE.
- branch_signal is 1 only while a conditional branch is in flight (CMP, RESOLVE, DONE); otherwise 0.
- taken, pc_sel and error hold their values through IDLE until the next start is accepted. error is then cleared.
- start while busy is ignored. alu_ack outside CMP is ignored.

## Timing
- Reset: all outputs are 0, the state is IDLE, the timeout counter is 0 and both performance counters are 0.
- With start at cycle N:
  - DECODE is cycle N+1.
  - Branch or JALR with alu_ack in its first CMP cycle (N+2): RESOLVE N+3, done at N+4.
  - Each additional wait cycle adds 1 to the done cycle.
  - JAL: done at N+3.
  - Non-branch or illegal funct3: done at N+2.
- Timeout: done and error assert ALU_TIMEOUT+1 cycles after CMP entry. alu_ack arriving in the same cycle as the expiry wins.
- alu_req and alu_op are combinational from the state; they are stable throughout CMP.
- Reset asserted mid-operation (any state) returns the block to IDLE on the next edge. No done pulse is produced.

## Configuration
- BRANCH_PERF_EN defined:
  - br_count increments in RESOLVE for each conditional branch.
  - br_taken_count increments in RESOLVE for each taken conditional branch.
  - Both counters saturate at all-ones and clear on reset.
- BRANCH_PERF_EN undefined: the counter logic is removed and both ports are tied to 0.

## Test plan
- BEQ (funct3=000) with alu_ack and alu_zero=1 at N+2 -> alu_op=00, branch_type=00, done at N+4, taken=1, pc_sel=01.
- BGEU (funct3=111), alu_ack after 3 wait cycles with alu_lsb=1 -> alu_op=10, branch_type=11, done at N+7, taken=0, pc_sel=00; with BRANCH_PERF_EN, br_count=1 and br_taken_count=0.
- JAL and JALR (alu_ack at N+2) back-to-back -> JAL: done at N+3, taken=1, pc_sel=01, alu_req never asserted. JALR: alu_op=11, done at N+4, pc_sel=10.
- funct3=010 with is_branch -> done and error at N+2, taken=0; a second start pulse at N+1 is ignored.
- No alu_ack with ALU_TIMEOUT=16 -> done and error 17 cycles after CMP entry, pc_sel=00.
- reset asserted in CMP -> next cycle busy=0, alu_req=0, all outputs 0, no done pulse, counters cleared.
